gate2_bist: RTL and testbench

- Self-test controller for a 2-input combinational gate under test (GUT).
- Drives inputs a/b through the full truth table 00, 01, 10, 11.
- Waits a settle interval per vector, samples the GUT output c and compares it against a parameterised expected truth table.
- Reports per-vector failures, an error count and an overall pass flag. Sits beside any 2-input gate (or_2, and_2, ...) to give a synthesisable, clocked check.

---
 rtl/gate2_bist.sv | 157 +++++++++++++++
 tb/tb_gate2_bist.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate2_bist.sv
// gate2_bist: clocked self-test controller for a 2-input combinational gate.
// Walks {a,b} through 00,01,10,11. Each vector is held SETTLE cycles, then the
// gate output c is sampled for one cycle and compared against TRUTH[{a,b}].
//
// Parameters:
//   TRUTH  - expected c per vector, bit index = {a,b} (default: OR)
//   SETTLE - cycles each vector is held before sampling, 1..15
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   start     - run request, only honoured in IDLE
//   c         - gate-under-test output
//   a, b      - gate-under-test inputs (registered)
//   busy      - high while a run is in progress (WAIT/SAMPLE)
//   done      - one-cycle pulse at the end of a run
//   pass      - last run had no mismatches; valid from the cycle after done
//   fail_vec  - per-vector mismatch flags, bit index = {a,b}
//   err_count - number of mismatching vectors, 0..4
module gate2_bist #(
  parameter logic [3:0]  TRUTH  = 4'b1110,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned VEC_W = 2;
  localparam int unsigned ERR_W = 3;
  localparam int unsigned NVEC  = 4;

  // SETTLE=0 is not supported; the reload value assumes SETTLE >= 1.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NVEC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   ab_q, ab_d;
  logic [NVEC-1:0]    fail_q, fail_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State register and all datapath/output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      ab_q    <= '0;
      fail_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      ab_q    <= ab_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    ab_d    = ab_q;
    fail_d  = fail_q;
    err_d   = err_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = '0;
          ab_d    = '0;
          cnt_d   = CNT_LOAD;
          fail_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_SAMPLE: begin
        // At most four increments, so err_count tops out at 4 without wrapping.
        if (c != TRUTH[vec_q]) begin
          fail_d[vec_q] = 1'b1;
          err_d         = err_q + ERR_W'(1);
        end
        if (vec_q != VEC_LAST) begin
          vec_d   = vec_q + VEC_W'(1);
          ab_d    = vec_q + VEC_W'(1);
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // fail_q already holds the last vector's result here.
        pass_d  = (fail_q == '0);
        ab_d    = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Status flags are registered copies of the Moore decode of the next state.
    busy_d = (state_d == S_WAIT) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  assign a         = ab_q[1];
  assign b         = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_vec  = fail_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_gate2_bist.sv
// Testbench for gate2_bist: two instances (default OR table with SETTLE=2, and
// an AND table with SETTLE=1) each driven by a modelled gate selectable at run
// time. Expected run results are queued when a run is started; a monitor per
// instance pops them on done and checks results, the {a,b} sequence and pass.
module tb_gate2_bist;

  localparam int unsigned ST0 = 2;
  localparam int unsigned ST1 = 1;

  typedef struct packed {
    logic [3:0] fv;
    logic [2:0] ec;
    logic       ps;
  } res_t;

  // Gate models: 0 = OR, 1 = stuck-at-0, 2 = AND, 3 = stuck-at-1.
  localparam int M_OR = 0, M_S0 = 1, M_AND = 2, M_S1 = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       glitch;
  logic       start_s [2];
  logic       c_s     [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [3:0] fv_s    [2];
  logic [2:0] ec_s    [2];
  int         mode    [2];
  int         done_cnt[2] = '{0, 0};
  res_t       exp_q   [2][$];

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  function automatic logic gut(input int m, input logic ga, input logic gb);
    case (m)
      M_OR:    return ga | gb;
      M_S0:    return 1'b0;
      M_AND:   return ga & gb;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int unsigned st_of(input int g);
    return (g == 0) ? ST0 : ST1;
  endfunction

  assign c_s[0] = gut(mode[0], a_s[0], b_s[0]) ^ glitch;
  assign c_s[1] = gut(mode[1], a_s[1], b_s[1]);

  gate2_bist u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .c(c_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .fail_vec(fv_s[0]), .err_count(ec_s[0])
  );

  gate2_bist #(.TRUTH(4'b1000), .SETTLE(ST1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .c(c_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .fail_vec(fv_s[1]), .err_count(ec_s[1])
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Per-instance monitor: logs {a,b} while busy, checks results on done and
  // pass/idle state in the following cycle.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic [1:0] ab_log[$];
    logic       pend = 1'b0;
    res_t       cur;

    always @(negedge clk) begin
      bit ok;
      if (pend) begin
        chk($sformatf("pass_after_done%0d", g), 16'(pass_s[g]), 16'(cur.ps));
        chk($sformatf("done_one_cycle%0d", g), 16'(done_s[g]), 16'd0);
        chk($sformatf("ab_idle%0d", g), 16'({a_s[g], b_s[g]}), 16'd0);
        pend = 1'b0;
      end
      if (done_s[g]) begin
        done_cnt[g]++;
        if (exp_q[g].size() == 0) begin
          chk($sformatf("unexpected_done%0d", g), 16'd1, 16'd0);
        end else begin
          cur  = exp_q[g].pop_front();
          pend = 1'b1;
          chk($sformatf("fail_vec%0d", g), 16'(fv_s[g]), 16'(cur.fv));
          chk($sformatf("err_count%0d", g), 16'(ec_s[g]), 16'(cur.ec));
          chk($sformatf("pass_low_in_done%0d", g), 16'(pass_s[g]), 16'd0);
          ok = (ab_log.size() == int'(4 * (st_of(g) + 1)));
          if (ok)
            for (int i = 0; i < ab_log.size(); i++)
              if (ab_log[i] != 2'(i / int'(st_of(g) + 1))) ok = 1'b0;
          chk($sformatf("ab_sequence%0d", g), 16'(ok), 16'd1);
        end
      end else if (busy_s[g]) begin
        ab_log.push_back({a_s[g], b_s[g]});
      end else begin
        ab_log.delete();
      end
    end
  end

  // Drive start for one edge; returns 1 time unit after the accepting edge.
  task automatic accept(input int g, input res_t e);
    @(negedge clk);
    start_s[g] = 1'b1;
    exp_q[g].push_back(e);
    @(posedge clk);
    #1;
    start_s[g] = 1'b0;
    chk($sformatf("busy_at_accept%0d", g), 16'({busy_s[g], a_s[g], b_s[g]}), 16'b100);
  endtask

  // Bounded wait for the next done; optionally checks latency from accept.
  task automatic wait_done(input int g, input bit chk_lat);
    int d0;
    int k;
    bit seen;
    d0   = done_cnt[g];
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 300) begin
      @(posedge clk);
      k++;
      if (done_cnt[g] != d0) seen = 1'b1;
    end
    chk($sformatf("done_seen%0d", g), 16'(seen), 16'd1);
    if (chk_lat && seen) chk($sformatf("done_latency%0d", g), 16'(k), 16'(4 * (st_of(g) + 1) + 1));
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] outs(input int g);
    return 16'({a_s[g], b_s[g], busy_s[g], done_s[g], pass_s[g], fv_s[g], ec_s[g]});
  endfunction

  initial begin
    int d0;
    int k;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    mode[0]    = M_OR;
    mode[1]    = M_AND;
    glitch     = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs0", outs(0), 16'd0);
    chk("reset_outs1", outs(1), 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", outs(0), 16'd0);

    // Good OR gate, single-cycle start.
    accept(0, {4'b0000, 3'd0, 1'b1});
    wait_done(0, 1'b1);

    // Stuck-at-0 with start held high, then back-to-back good run.
    d0 = done_cnt[0];
    mode[0] = M_S0;
    @(negedge clk);
    start_s[0] = 1'b1;
    exp_q[0].push_back({4'b1110, 3'd3, 1'b0});
    @(posedge clk);
    #1;
    chk("pass_drop_at_accept", 16'({pass_s[0], busy_s[0]}), 16'b01);
    k = 0;
    while (!done_s[0] && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_first_done", 16'(done_s[0]), 16'd1);
    mode[0] = M_OR;
    exp_q[0].push_back({4'b0000, 3'd0, 1'b1});
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_clear", 16'({busy_s[0], fv_s[0], ec_s[0]}), 16'({1'b1, 4'b0000, 3'd0}));
    start_s[0] = 1'b0;
    wait_done(0, 1'b0);
    chk("b2b_done_count", 16'(done_cnt[0] - d0), 16'd2);

    // AND gate against the OR table.
    mode[0] = M_AND;
    accept(0, {4'b0110, 3'd2, 1'b0});
    wait_done(0, 1'b1);

    // AND table instance: AND gate passes, OR gate fails on 01 and 10.
    accept(1, {4'b0000, 3'd0, 1'b1});
    wait_done(1, 1'b1);
    mode[1] = M_OR;
    accept(1, {4'b0110, 3'd2, 1'b0});
    wait_done(1, 1'b1);

    // start re-asserted and c glitched during WAIT of vector 10.
    mode[0] = M_OR;
    d0 = done_cnt[0];
    accept(0, {4'b0000, 3'd0, 1'b1});
    repeat (6) @(posedge clk);
    #1;
    chk("wait_vec10", 16'({busy_s[0], a_s[0], b_s[0]}), 16'b110);
    start_s[0] = 1'b1;
    glitch     = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    glitch     = 1'b0;
    wait_done(0, 1'b0);
    repeat (4) @(posedge clk);
    chk("restart_one_done", 16'(done_cnt[0] - d0), 16'd1);

    // Reset mid-cycle during SAMPLE of vector 01, stuck-at-1 gate.
    mode[0] = M_S1;
    d0 = done_cnt[0];
    accept(0, {4'b0000, 3'd0, 1'b0});
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset", 16'({busy_s[0], a_s[0], b_s[0], fv_s[0], ec_s[0]}),
        16'({1'b1, 1'b0, 1'b1, 4'b0001, 3'd1}));
    rst_n = 1'b0;
    #1;
    chk("mid_run_reset", outs(0), 16'd0);
    exp_q[0].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("no_done_after_reset", 16'(done_cnt[0] - d0), 16'd0);

    // Normal run after reset.
    mode[0] = M_OR;
    accept(0, {4'b0000, 3'd0, 1'b1});
    wait_done(0, 1'b1);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
